ifetch_unit: RTL and testbench

- Instruction fetch stage of the MIPS core, directly upstream of the main decoder.
- Holds the PC and requests instructions from a variable-latency instruction memory using a req/ack handshake.
- Presents the fetched instruction, with its Op/Funct fields split out, to the decoder.
- Computes the next PC from the decoder's 2-bit NPCOp once the core accepts the current instruction.

---
 rtl/ifetch_unit_if.sv | 15 +
 rtl/ifetch_unit.sv | 160 ++++++++++++++++
 tb/tb_ifetch_unit.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_unit_if.sv
// ifetch_unit_if: instruction-memory request/acknowledge bus.
//   req   - fetch request, held until ack
//   addr  - byte address of the fetch
//   ack   - memory returns data this cycle
//   rdata - instruction word, valid when ack=1
// Modports: master (fetch unit side), slave (memory side).
interface ifetch_unit_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/ifetch_unit.sv
// ifetch_unit: MIPS instruction fetch stage.
// Holds the PC, fetches over a req/ack bus from a variable-latency memory,
// presents the instruction (with op/funct split out) to the decoder and
// computes the next PC from npc_op when the core accepts the instruction.
//
// Ports:
//   clk         - core clock, rising edge
//   rstn        - asynchronous active-low reset
//   imem        - ifetch_unit_if.master: req/addr out, ack/rdata in
//   inst        - registered instruction
//   op, funct   - inst[31:26], inst[5:0]
//   inst_valid  - inst/pc valid for the core
//   inst_accept - core retires inst this cycle (npc_op, rs_data valid)
//   npc_op      - 00 PLUS4, 01 BRANCH, 10 JUMP, 11 JUMPR
//   rs_data     - jr/jalr target
//   pc          - address of inst
//   pc_plus4    - pc+4, link value
//   fetch_err   - sticky fetch timeout flag
//
// Optional feature, macro IFU_TIMEOUT_EN: after TIMEOUT_CYC cycles without
// ack the request is abandoned and a NOP is delivered with fetch_err set.
// Without the macro fetch_err is tied 0 and the unit waits indefinitely.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic                clk,
    input  logic                rstn,
    ifetch_unit_if.master       imem,
    output logic [31:0]         inst,
    output logic [5:0]          op,
    output logic [5:0]          funct,
    output logic                inst_valid,
    input  logic                inst_accept,
    input  logic [1:0]          npc_op,
    input  logic [31:0]         rs_data,
    output logic [31:0]         pc,
    output logic [31:0]         pc_plus4,
    output logic                fetch_err
);

    typedef enum logic [1:0] {StIdle, StReq, StHold} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, inst_q;
    logic [31:0] next_pc;
    logic [31:0] br_off;
    logic [31:0] fetch_data;
    logic        timeout;
    logic        fetch_done;
    logic        unused_rs;

    // jr/jalr targets are forced word aligned, so the low bits never matter.
    assign unused_rs = ^rs_data[1:0];

`ifdef IFU_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

    logic [CntW-1:0] wait_cnt_q;
    logic            err_q;

    // Counter sits at 0 outside StReq, so every request starts from 0.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wait_cnt_q <= '0;
        end else if (state_q != StReq) begin
            wait_cnt_q <= '0;
        end else if (!imem.ack) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
        end
    end

    // Fires in the cycle whose missing ack would bring the count to TIMEOUT_CYC.
    assign timeout = (state_q == StReq) && !imem.ack &&
                     (wait_cnt_q == CntW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_q <= 1'b0;
        end else if (timeout) begin
            err_q <= 1'b1;
        end
    end

    assign fetch_err = err_q;
`else
    assign timeout   = 1'b0;
    assign fetch_err = 1'b0;
`endif

    assign fetch_done = (state_q == StReq) && (imem.ack || timeout);
    assign fetch_data = timeout ? 32'h0000_0000 : imem.rdata;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  state_d = StReq;
            StReq:   if (fetch_done) state_d = StHold;
            StHold:  if (inst_accept) state_d = StReq;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        imem.req   = 1'b0;
        inst_valid = 1'b0;
        unique case (state_q)
            StReq:   imem.req = !timeout;
            StHold:  inst_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_q   <= RESET_PC;
            inst_q <= 32'h0000_0000;
        end else begin
            if (fetch_done) begin
                inst_q <= fetch_data;
            end
            if (state_q == StHold && inst_accept) begin
                pc_q <= next_pc;
            end
        end
    end

    assign pc_plus4 = pc_q + 32'd4;
    assign br_off   = {{14{inst_q[15]}}, inst_q[15:0], 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        unique case (npc_op)
            2'b00: next_pc = pc_plus4;
            2'b01: next_pc = pc_plus4 + br_off;
            2'b10: next_pc = {pc_plus4[31:28], inst_q[25:0], 2'b00};
            2'b11: next_pc = {rs_data[31:2], 2'b00};
            default: next_pc = pc_plus4;
        endcase
    end

    assign imem.addr = pc_q;
    assign pc        = pc_q;
    assign inst      = inst_q;
    assign op        = inst_q[31:26];
    assign funct     = inst_q[5:0];

endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] inst;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        inst_valid;
    logic        inst_accept = 1'b0;
    logic [1:0]  npc_op = 2'b00;
    logic [31:0] rs_data = 32'h0;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_err;

    ifetch_unit_if imem ();

    ifetch_unit #(
        .RESET_PC    (32'h0000_0000),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .imem        (imem),
        .inst        (inst),
        .op          (op),
        .funct       (funct),
        .inst_valid  (inst_valid),
        .inst_accept (inst_accept),
        .npc_op      (npc_op),
        .rs_data     (rs_data),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .fetch_err   (fetch_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit exp_err = 1'b0;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  npc;
        logic [31:0] rs;
        int          ack_dly;
        int          acc_dly;
        logic [31:0] exp_pc;
        logic [5:0]  exp_op;
        logic [5:0]  exp_funct;
        logic [31:0] exp_next;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference next-PC, straight from the architectural rules.
    function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] ins,
                                               input logic [1:0] sel, input logic [31:0] rs);
        logic [31:0] p4;
        int          imm;
        p4  = cur + 32'd4;
        imm = int'($signed(ins[15:0]));
        case (sel)
            2'd0:    return p4;
            2'd1:    return p4 + 32'(imm * 4);
            2'd2:    return (p4 & 32'hF000_0000) | (32'(ins[25:0]) * 32'd4);
            default: return rs - (rs % 32'd4);
        endcase
    endfunction

    task automatic wait_req();
        bit ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (imem.req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) chk("req_wait_expired", 64'd0, 64'd1);
    endtask

    // One fetch/accept transaction; entered and left at a negedge.
    task automatic fetch(input logic [31:0] exp_pc, input logic [31:0] data, input int ack_dly,
                         input int acc_dly, input logic [1:0] sel, input logic [31:0] rs,
                         input logic [31:0] exp_next);
        wait_req();
        chk("req_addr", {31'd0, imem.req, imem.addr}, {31'd0, 1'b1, exp_pc});
        for (int d = 0; d < ack_dly; d++) begin
            imem.ack    = 1'b0;
            inst_accept = 1'($urandom_range(1));
            @(negedge clk);
            chk("req_held_addr_stable", {31'd0, imem.req, imem.addr}, {31'd0, 1'b1, exp_pc});
            chk("no_valid_while_req", {63'd0, inst_valid}, 64'd0);
        end
        inst_accept = 1'b0;
        imem.ack    = 1'b1;
        imem.rdata  = data;
        @(negedge clk);
        for (int d = 0; d <= acc_dly; d++) begin
            chk("hold_valid_req", {62'd0, inst_valid, imem.req}, {62'd0, 2'b10});
            chk("hold_inst", {32'd0, inst}, {32'd0, data});
            chk("hold_pc", {32'd0, pc}, {32'd0, exp_pc});
            chk("hold_pc_plus4", {32'd0, pc_plus4}, {32'd0, exp_pc + 32'd4});
            chk("hold_op_funct", {52'd0, op, funct}, {52'd0, data[31:26], data[5:0]});
            chk("fetch_err", {63'd0, fetch_err}, {63'd0, exp_err});
            if (d < acc_dly) begin
                imem.ack   = 1'($urandom_range(1));
                imem.rdata = $urandom;
                npc_op     = 2'($urandom_range(3));
                rs_data    = $urandom;
                @(negedge clk);
            end
        end
        imem.ack    = 1'b0;
        inst_accept = 1'b1;
        npc_op      = sel;
        rs_data     = rs;
        @(negedge clk);
        inst_accept = 1'b0;
        chk("next_req_addr", {31'd0, imem.req, imem.addr}, {31'd0, 1'b1, exp_next});
        chk("valid_dropped", {63'd0, inst_valid}, 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] mpc;
        logic [31:0] d;
        logic [1:0]  s;
        logic [31:0] r;
        logic [31:0] nx;

        imem.ack   = 1'b0;
        imem.rdata = 32'h0;

        //        rdata         npc    rs             ackd accd exp_pc        op     funct  next
        vt[0] = '{32'h2008_0005, 2'b00, 32'h0,        0, 0, 32'h0000_0000, 6'h08, 6'h05, 32'h0000_0004};
        vt[1] = '{32'h0800_0004, 2'b10, 32'h0,        1, 0, 32'h0000_0004, 6'h02, 6'h04, 32'h0000_0010};
        vt[2] = '{32'h1000_FFFE, 2'b01, 32'h0,        0, 0, 32'h0000_0010, 6'h04, 6'h3E, 32'h0000_000C};
        vt[3] = '{32'h0000_0008, 2'b11, 32'h9000_0003, 0, 1, 32'h0000_000C, 6'h00, 6'h08, 32'h9000_0000};
        vt[4] = '{32'h0800_0040, 2'b10, 32'h0,        5, 3, 32'h9000_0000, 6'h02, 6'h00, 32'h9000_0100};
        vt[5] = '{32'h0000_0009, 2'b11, 32'h0000_2003, 0, 0, 32'h9000_0100, 6'h00, 6'h09, 32'h0000_2000};
        vt[6] = '{32'h1000_7FFF, 2'b01, 32'h0,        2, 2, 32'h0000_2000, 6'h04, 6'h3F, 32'h0002_2000};
        vt[7] = '{32'h0000_0008, 2'b11, 32'hFFFF_FFFF, 0, 0, 32'h0002_2000, 6'h00, 6'h08, 32'hFFFF_FFFC};
        vt[8] = '{32'h2008_0005, 2'b00, 32'h0,        0, 0, 32'hFFFF_FFFC, 6'h08, 6'h05, 32'h0000_0000};
        vt[9] = '{32'h0000_0008, 2'b11, 32'h0000_0040, 0, 0, 32'h0000_0000, 6'h00, 6'h08, 32'h0000_0040};

        // Reset state
        @(negedge clk);
        chk("rst_req_valid", {62'd0, imem.req, inst_valid}, 64'd0);
        chk("rst_pc_addr", {pc, imem.addr}, 64'd0);
        chk("rst_inst", {32'd0, inst}, 64'd0);
        chk("rst_err", {63'd0, fetch_err}, 64'd0);
        rstn = 1'b1;
        @(negedge clk);
        chk("idle_then_req", {63'd0, imem.req}, 64'd1);

        for (int i = 0; i < 10; i++) begin
            fetch(vt[i].exp_pc, vt[i].rdata, vt[i].ack_dly, vt[i].acc_dly, vt[i].npc,
                  vt[i].rs, vt[i].exp_next);
            chk($sformatf("vec%0d_op_funct_kept", i), {52'd0, op, funct},
                {52'd0, vt[i].exp_op, vt[i].exp_funct});
        end

        // Reset mid-request at pc=0x40, then a stray ack while idle
        chk("pre_rst_req", {31'd0, imem.req, imem.addr}, {31'd0, 1'b1, 32'h40});
        rstn = 1'b0;
        #1;
        chk("rst_drops_req", {63'd0, imem.req}, 64'd0);
        chk("rst_pc", {32'd0, pc}, 64'd0);
        @(negedge clk);
        imem.ack   = 1'b1;
        imem.rdata = 32'hDEAD_BEEF;
        rstn       = 1'b1;
        @(negedge clk);
        chk("post_rst_req_addr", {31'd0, imem.req, imem.addr}, {31'd0, 1'b1, 32'h0});
        chk("stray_ack_ignored", {31'd0, inst_valid, inst}, 64'd0);
        imem.ack = 1'b0;
        @(negedge clk);
        chk("still_req", {62'd0, imem.req, inst_valid}, {62'd0, 2'b10});

        // Randomised transactions against the reference model
        mpc = 32'h0;
        for (int t = 0; t < 40; t++) begin
            d  = $urandom;
            s  = 2'($urandom_range(3));
            r  = $urandom;
            nx = model_next(mpc, d, s, r);
            fetch(mpc, d, int'($urandom_range(4)), int'($urandom_range(3)), s, r, nx);
            mpc = nx;
        end

`ifdef IFU_TIMEOUT_EN
        // No ack: request abandoned, NOP delivered, sticky error
        wait_req();
        for (int c = 0; c < 15; c++) begin
            chk("to_req_high", {63'd0, imem.req}, 64'd1);
            @(negedge clk);
        end
        chk("to_req_dropped", {63'd0, imem.req}, 64'd0);
        @(negedge clk);
        chk("to_nop", {31'd0, inst_valid, inst}, {31'd0, 1'b1, 32'h0});
        chk("to_err", {63'd0, fetch_err}, 64'd1);
        exp_err = 1'b1;
        nx = model_next(mpc, 32'h0, 2'b00, 32'h0);
        inst_accept = 1'b1;
        npc_op      = 2'b00;
        @(negedge clk);
        inst_accept = 1'b0;
        chk("to_next_addr", {32'd0, imem.addr}, {32'd0, nx});
        mpc = nx;
        nx  = model_next(mpc, 32'h2008_0005, 2'b00, 32'h0);
        fetch(mpc, 32'h2008_0005, 0, 0, 2'b00, 32'h0, nx);
        chk("to_err_sticky", {63'd0, fetch_err}, 64'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
